// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: CPU-side initiator for the shared memory bus.
// Accepts one load/store at a time from the execute stage, checks its
// alignment, runs the data/address phases on the shared 32-bit bus, waits
// for the responder's done_or_valid and returns load data with a one-cycle
// resp_valid pulse. The top level builds the tri-state bus from
// bus_out/bus_drive.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_*                 core request (valid/ready, write, size, sign, addr, wdata)
//   resp_*                completion pulse, load data, error flag
//   mem_*                 bus control lines to the responder
//   bus_out/bus_drive     value and tri-state enable toward memory
//   bus_in                resolved bus value
//
// Optional build macro: MEM_TIMEOUT_EN adds an address-phase timeout of
// TIMEOUT_CYCLES cycles that aborts the access with resp_error = 1.
module mem_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_read_write,
  output logic                  mem_data_address,
  output logic                  mem_input_enable,
  output logic                  mem_output_enable,
  output logic [1:0]            mem_size,
  output logic                  mem_sign,
  input  logic                  mem_done_or_valid,
  output logic [31:0]           bus_out,
  output logic                  bus_drive,
  input  logic [31:0]           bus_in
);

  // S_CHECK spends one cycle judging alignment on the latched request.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic                  first_q, first_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic                  rw_q, rw_d;
  logic                  da_q, da_d;
  logic                  ie_q, ie_d;
  logic                  oe_q, oe_d;
  logic [31:0]           bus_out_q, bus_out_d;

  logic                  misaligned_c;
  logic                  done_qual_c;
  logic                  timeout_c;
  logic                  err_set_c;
  logic                  in_addr_phase_c;

  // Halfwords need addr[0] = 0; word and size 3 need addr[1:0] = 0.
  assign misaligned_c = ((size_q == 2'd1) && addr_q[0]) ||
                        (size_q[1] && (addr_q[1:0] != 2'b00));

  assign in_addr_phase_c = (state_q == S_WR_ADDR) || (state_q == S_RD_ADDR);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter reads k-1 in the k-th address-phase cycle.
  assign timeout_c = in_addr_phase_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_addr_phase_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_c = 1'b0;
`endif

  // Next-state, request latch and registered-output next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    size_d      = size_q;
    sign_d      = sign_q;
    err_set_c   = 1'b0;
    // The responder may still hold done from the previous access, so the
    // first cycle of an address phase never counts.
    done_qual_c = mem_done_or_valid && !first_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          size_d  = req_size;
          sign_d  = req_sign;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (misaligned_c) begin
          state_d   = S_RESP;
          err_set_c = 1'b1;
        end else if (write_q) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_WR_DATA: begin
        state_d = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (done_qual_c) begin
          state_d = S_RESP;
        end else if (timeout_c) begin
          state_d   = S_RESP;
          err_set_c = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (done_qual_c) begin
          state_d = S_RD_DATA;
        end else if (timeout_c) begin
          state_d   = S_RESP;
          err_set_c = 1'b1;
        end
      end
      S_RD_DATA: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    first_d = (state_d != state_q);

    // Outputs are registered from the next state so they line up with it.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    rw_d         = (state_d == S_WR_DATA) || (state_d == S_WR_ADDR);
    da_d         = (state_d == S_WR_ADDR) || (state_d == S_RD_ADDR);
    ie_d         = (state_d == S_WR_DATA) || (state_d == S_WR_ADDR) ||
                   (state_d == S_RD_ADDR);
    oe_d         = (state_d == S_RD_DATA);

    bus_out_d = '0;
    if (state_d == S_WR_DATA) begin
      bus_out_d = wdata_q;
    end else if (da_d) begin
      bus_out_d = 32'(addr_q);
    end

    // Response fields change only on entry to RESP and hold otherwise.
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    if (state_d == S_RESP) begin
      resp_rdata_d = (state_q == S_RD_DATA) ? bus_in : '0;
      resp_error_d = err_set_c;
    end
  end

  // State, request latch and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      sign_q       <= 1'b0;
      first_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      rw_q         <= 1'b0;
      da_q         <= 1'b0;
      ie_q         <= 1'b0;
      oe_q         <= 1'b0;
      bus_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      first_q      <= first_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      rw_q         <= rw_d;
      da_q         <= da_d;
      ie_q         <= ie_d;
      oe_q         <= oe_d;
      bus_out_q    <= bus_out_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_error        = resp_error_q;
  assign mem_read_write    = rw_q;
  assign mem_data_address  = da_q;
  assign mem_input_enable  = ie_q;
  assign mem_output_enable = oe_q;
  assign mem_size          = size_q;
  assign mem_sign          = sign_q;
  assign bus_out           = bus_out_q;
  assign bus_drive         = ie_q;

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Initiator (CPU side) of the shared memory bus protocol: read_write, data_address, input_enable, output_enable, size, sign, done_or_valid, plus a 32-bit shared data/address bus.
- Accepts single load/store requests from the core's execute stage.
- Sequences the data/address phases on the bus, waits for the memory responder's done_or_valid and returns load data.
- Sits between the core pipeline and the BRAM memory block; the top level builds the tri-state bus from bus_out/bus_drive.

Parameters:
- TIMEOUT_CYCLES, 64: address-phase cycles before abort (used only with MEM_TIMEOUT_EN).
- ADDR_WIDTH, 32: request address width; the bus is always 32 bits.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  initiator idle, request accepted this cycle if req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 halfword, 2 word, 3 treated as word.
- req_sign  in  1  sign-extend loads.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data (0 for stores and errors).
- resp_error  out  1  misaligned access, or timeout.
- mem_read_write  out  1  0 read, 1 write.
- mem_data_address  out  1  0 = bus carries data, 1 = bus carries address.
- mem_input_enable  out  1  initiator drives bus toward memory.
- mem_output_enable  out  1  memory drives bus toward initiator.
- mem_size  out  2  registered req_size.
- mem_sign  out  1  registered req_sign.
- mem_done_or_valid  in  1  responder completion flag.
- bus_out  out  32  value driven onto bus.
- bus_drive  out  1  tri-state enable for bus_out; equals mem_input_enable.
- bus_in  in  32  resolved bus value.

Behaviour:
- Reset values: req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_error = 0.
- Reset values (bus side): every mem_* output = 0; bus_out = 0; bus_drive = 0; state IDLE.
- Reset mid-transaction: all enables drop at that edge; no resp_valid is issued; the request is lost.
- State IDLE:
  - req_ready = 1. On req_valid, latch addr, wdata, write, size, sign; req_ready = 0 from the next cycle.
  - Alignment check: halfword needs addr[0] = 0; word/size 3 needs addr[1:0] = 0.
  - Misaligned: go to RESP with resp_error = 1 and no bus activity.
  - Aligned store goes to WR_DATA; aligned load goes to RD_ADDR.
- State WR_DATA:
  - Drives read_write = 1, data_address = 0, input_enable = 1, bus_out = wdata.
  - Lasts exactly 1 cycle; done_or_valid is ignored. Then WR_ADDR.
- State WR_ADDR:
  - Drives read_write = 1, data_address = 1, input_enable = 1, bus_out = {addr, zero-extended to 32}.
  - Wait for done_or_valid, then RESP.
- State RD_ADDR:
  - Drives read_write = 0, data_address = 1, input_enable = 1, bus_out = address.
  - Wait for done_or_valid, then RD_DATA.
- Stale-flag rule:
  - In WR_ADDR and RD_ADDR, done_or_valid is ignored in the first cycle of the phase; the responder holds it from the previous access.
  - It is qualified from the second cycle onward, so minimum address-phase length is 2 cycles.
- State RD_DATA:
  - input_enable = 0, bus_drive = 0, output_enable = 1 for exactly 1 cycle.
  - bus_in is registered into resp_rdata at the end of that cycle. Then RESP.
  - Data passes through unchanged: the responder has already applied size/sign extension.
- State RESP:
  - resp_valid = 1 for one cycle; all mem enables = 0; then IDLE.
  - No backpressure: the core must accept the pulse.
  - resp_rdata and resp_error hold until the next RESP.
- Latency, req_valid to resp_valid, with N = address-phase cycles (N ≥ 2):
  - Load: N + 3 cycles.
  - Store: N + 3 cycles.
  - Misaligned: 2 cycles.
- Bus turnaround: input_enable and output_enable are never high in the same cycle. bus_drive is low whenever output_enable is high.
- mem_size/mem_sign are stable from acceptance until RESP.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WR_ADDR/RD_ADDR and increments each cycle in the phase.
  - When it reaches TIMEOUT_CYCLES without a qualified done_or_valid: drop all enables, go to RESP with resp_error = 1 and resp_rdata = 0.
  - A done_or_valid arriving in the same cycle as the timeout wins: normal completion.
- MEM_TIMEOUT_EN undefined: no counter; the address phase waits indefinitely; resp_error reports only misalignment.

Test Plan:
- Word load, addr 0x0000_0008, responder returns 0x0020_8133 with done 3 cycles into the phase -> resp_valid 6 cycles after accept, resp_rdata = 0x0020_8133, resp_error = 0, no cycle with both enables high.
- Word store, addr 0x0000_0064, wdata 0xDEAD_BEEF -> one cycle bus = 0xDEAD_BEEF with data_address = 0, then bus = 0x64 with data_address = 1 until done; resp_valid with resp_rdata = 0.
- Halfword load at 0x0000_0003 -> resp_valid 2 cycles later, resp_error = 1, mem_input_enable never asserted.
- Back-to-back loads with done_or_valid held high throughout -> second transaction still spends ≥ 2 address-phase cycles; second resp_rdata equals bus_in from its own RD_DATA cycle.
- reset asserted during RD_ADDR -> next cycle all mem_* = 0, req_ready = 1, no resp_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 8, done never asserted -> resp_valid with resp_error = 1, resp_rdata = 0 exactly 8 phase cycles after entering RD_ADDR.
